// File: rtl/mux8_scan_ctrl.sv
// Drives a latched byte onto an external 8:1 mux, steps its select through 0..7,
// samples y at each step and reports the rebuilt byte and whether it survived intact.
module mux8_scan_ctrl #(
   parameter int DWELL = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data_in,
   input  logic       y,
   output logic       i0,
   output logic       i1,
   output logic       i2,
   output logic       i3,
   output logic       i4,
   output logic       i5,
   output logic       i6,
   output logic       i7,
   output logic       s0,
   output logic       s1,
   output logic       s2,
   output logic       busy,
   output logic       done,
   output logic [7:0] rx_byte,
   output logic       match
);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      SAMPLE,
      DONE_ST
   } state_t;

   // DRIVE lasts DWELL cycles, so the counter's terminal value is DWELL-1
   localparam logic [3:0] CNT_LAST = 4'(DWELL - 1);

   state_t     state_reg;
   logic [7:0] data_reg;
   logic [7:0] rx_reg;
   logic [2:0] sel_reg;
   logic [3:0] cnt_reg;
   logic [7:0] rx_final;

   // The last sample is folded in directly so rx_byte/match are valid with done
   assign rx_final = {y, rx_reg[6:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         data_reg  <= '0;
         rx_reg    <= '0;
         sel_reg   <= '0;
         cnt_reg   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rx_byte   <= '0;
         match     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  data_reg  <= data_in;
                  sel_reg   <= 3'd0;
                  cnt_reg   <= 4'd0;
                  busy      <= 1'b1;
                  state_reg <= DRIVE;
               end
            end
            DRIVE: begin
               cnt_reg <= cnt_reg + 4'd1;
               if (cnt_reg == CNT_LAST) begin
                  state_reg <= SAMPLE;
               end
            end
            SAMPLE: begin
               rx_reg[sel_reg] <= y;
               if (sel_reg == 3'd7) begin
                  rx_byte   <= rx_final;
                  match     <= (rx_final == data_reg);
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= DONE_ST;
               end else begin
                  sel_reg   <= sel_reg + 3'd1;
                  cnt_reg   <= 4'd0;
                  state_reg <= DRIVE;
               end
            end
            DONE_ST: begin
               done      <= 1'b0;
               sel_reg   <= 3'd0;
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign i0 = data_reg[0];
   assign i1 = data_reg[1];
   assign i2 = data_reg[2];
   assign i3 = data_reg[3];
   assign i4 = data_reg[4];
   assign i5 = data_reg[5];
   assign i6 = data_reg[6];
   assign i7 = data_reg[7];

   assign s0 = sel_reg[0];
   assign s1 = sel_reg[1];
   assign s2 = sel_reg[2];

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Bench for mux8_scan_ctrl: two instances (DWELL=1 and DWELL=3) each scanning an
// emulated mux whose output can be true, stuck, or corrupted on one select.
module tb_mux8_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] start_v = '0;
   logic [1:0] y_v;
   logic [1:0] busy_v;
   logic [1:0] done_v;
   logic [1:0] match_v;
   logic [7:0] din_a [2];
   logic [7:0] i_a   [2];
   logic [7:0] rx_a  [2];
   logic [2:0] sel_a [2];
   int         mode_s [2];
   int         bad_s  [2];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // y modes: 0 true mux, 1 stuck at 0, 2 stuck at 1, 3 true mux inverted at select bad_s
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_unit
         assign y_v[gi] = (mode_s[gi] == 1) ? 1'b0 :
                          (mode_s[gi] == 2) ? 1'b1 :
                          (i_a[gi][sel_a[gi]] ^ (mode_s[gi] == 3 && sel_a[gi] == bad_s[gi][2:0]));

         mux8_scan_ctrl #(.DWELL(gi == 0 ? 1 : 3)) dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start_v[gi]),
            .data_in (din_a[gi]),
            .y       (y_v[gi]),
            .i0      (i_a[gi][0]),
            .i1      (i_a[gi][1]),
            .i2      (i_a[gi][2]),
            .i3      (i_a[gi][3]),
            .i4      (i_a[gi][4]),
            .i5      (i_a[gi][5]),
            .i6      (i_a[gi][6]),
            .i7      (i_a[gi][7]),
            .s0      (sel_a[gi][0]),
            .s1      (sel_a[gi][1]),
            .s2      (sel_a[gi][2]),
            .busy    (busy_v[gi]),
            .done    (done_v[gi]),
            .rx_byte (rx_a[gi]),
            .match   (match_v[gi])
         );
      end
   endgenerate

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: what the byte looks like after passing through the emulated mux
   function automatic logic [7:0] exp_rx(input logic [7:0] d, input int m, input int k);
      case (m)
         1:       return 8'h00;
         2:       return 8'hFF;
         3:       return d ^ (8'h01 << k);
         default: return d;
      endcase
   endfunction

   task automatic check_idle_zero(input int u, input string tag);
      check({tag, "_i"}, i_a[u], 0);
      check({tag, "_sel"}, sel_a[u], 0);
      check({tag, "_busy"}, busy_v[u], 0);
      check({tag, "_done"}, done_v[u], 0);
      check({tag, "_rx"}, rx_a[u], 0);
      check({tag, "_match"}, match_v[u], 0);
   endtask

   task automatic run_scan(input int u, input logic [7:0] d, input int m, input int k);
      int dw;
      int cyc;
      int limit;
      logic [7:0] er;
      dw = (u == 0) ? 1 : 3;
      limit = 8 * (dw + 1) + 4;
      mode_s[u] = m;
      bad_s[u] = k;
      er = exp_rx(d, m, k);
      @(negedge clk);
      start_v[u] = 1'b1;
      din_a[u] = d;
      @(negedge clk);
      start_v[u] = 1'b0;
      din_a[u] = 8'($urandom);
      cyc = 1;
      while (!done_v[u] && cyc <= limit) begin
         check("sel_step", sel_a[u], (cyc - 1) / (dw + 1));
         check("busy", busy_v[u], 1);
         check("i_stable", i_a[u], d);
         // start and data_in noise while busy must be ignored
         start_v[u] = 1'($urandom);
         din_a[u] = 8'($urandom);
         @(negedge clk);
         cyc++;
      end
      check("done_cycle", cyc, 8 * (dw + 1) + 1);
      check("done", done_v[u], 1);
      check("rx_byte", rx_a[u], er);
      check("match", match_v[u], (er == d));
      check("busy_at_done", busy_v[u], 0);
      start_v[u] = 1'($urandom);
      @(negedge clk);
      start_v[u] = 1'b0;
      check("done_pulse", done_v[u], 0);
      check("sel_wrap", sel_a[u], 0);
      check("i_hold", i_a[u], d);
      check("rx_hold", rx_a[u], er);
      check("busy_idle", busy_v[u], 0);
      $display("scan unit=%0d dwell=%0d data=%02h mode=%0d k=%0d rx=%02h match=%0b done_cyc=%0d",
               u, dw, d, m, k, rx_a[u], match_v[u], cyc);
   endtask

   initial begin
      int cyc;
      int last;
      int ndone;
      for (int u = 0; u < 2; u++) begin
         din_a[u] = '0;
         mode_s[u] = 0;
         bad_s[u] = 0;
      end

      repeat (3) @(negedge clk);
      check_idle_zero(0, "rst0");
      check_idle_zero(1, "rst1");
      rst = 1'b0;

      // Directed cases
      run_scan(0, 8'hAA, 0, 0);
      run_scan(0, 8'hFF, 1, 0);
      run_scan(0, 8'h01, 2, 0);
      run_scan(1, 8'h5A, 0, 0);
      run_scan(0, 8'hC3, 3, 5);

      // start held high: scans back-to-back, done every 18 cycles
      @(negedge clk);
      mode_s[0] = 0;
      din_a[0] = 8'h3C;
      start_v[0] = 1'b1;
      cyc = 0;
      last = -1;
      ndone = 0;
      repeat (60) begin
         @(negedge clk);
         cyc++;
         if (done_v[0]) begin
            if (last < 0) check("first_done", cyc, 17);
            else check("done_period", cyc - last, 18);
            check("held_rx", rx_a[0], 8'h3C);
            last = cyc;
            ndone++;
         end
      end
      start_v[0] = 1'b0;
      check("held_ndone", ndone, 3);
      cyc = 0;
      while ((busy_v[0] || done_v[0]) && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("held_drain", busy_v[0], 0);
      $display("held-start unit=0 dones=%0d", ndone);

      // Reset mid-scan at select 4
      start_v[0] = 1'b1;
      din_a[0] = 8'h96;
      @(negedge clk);
      start_v[0] = 1'b0;
      cyc = 0;
      while (sel_a[0] != 3'd4 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("reach_sel4", sel_a[0], 4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle_zero(0, "midrst");
      $display("mid-scan reset unit=0 after %0d cycles", cyc);
      run_scan(0, 8'h80, 0, 0);

      // Randomized scans on both instances
      for (int n = 0; n < 12; n++) begin
         run_scan(int'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
